// File: rtl/jpeg_raster2blk.sv
// rtl/jpeg_raster2blk.sv - raster-to-8x8-block reorder buffer with ping-pong stripe banks
module jpeg_raster2blk #(
    parameter int MAX_BLK_COLS = 80,
    parameter int MAX_BLK_ROWS = 60
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [$clog2(MAX_BLK_COLS+1)-1:0] cfg_blk_cols,
    input  logic [$clog2(MAX_BLK_ROWS+1)-1:0] cfg_blk_rows,
    input  logic                              pix_valid,
    output logic                              pix_ready,
    input  logic [23:0]                       pix_data,
    output logic                              blk_valid,
    input  logic                              blk_ready,
    output logic [31:0]                       blk_data,
    output logic                              blk_last_pix,
    output logic                              blk_last_block,
    output logic                              busy,
    output logic                              done
);
    localparam int CW    = $clog2(MAX_BLK_COLS + 1);
    localparam int RW    = $clog2(MAX_BLK_ROWS + 1);
    localparam int XW    = CW + 3;
    localparam int MAX_W = MAX_BLK_COLS * 8;
    localparam int DEPTH = 16 * MAX_W;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] cols_q;
    logic [RW-1:0] rows_q;
    logic          cfg_ok, start_acc, beat_fire, final_fire;

    logic          wr_ptr, wr_fire, line_end, stripe_end;
    logic [XW-1:0] wr_col, last_col;
    logic [2:0]    wr_line;
    logic [RW-1:0] stripes_in;

    logic          rd_ptr, issue, rd_blk_last, rd_stripe_last, blk_end;
    logic [CW-1:0] rd_blk;
    logic [2:0]    rd_row, rd_col;
    logic [RW-1:0] rd_stripe;

    logic [1:0]    bank_full, set_mask, clr_mask;
    logic          out_bank, out_bank_last, bank_drain;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [23:0]   mem [DEPTH];

    assign cfg_ok = (cfg_blk_cols != '0) && (int'(cfg_blk_cols) <= MAX_BLK_COLS) &&
                    (cfg_blk_rows != '0) && (int'(cfg_blk_rows) <= MAX_BLK_ROWS);
    assign start_acc  = (state == IDLE) && start && cfg_ok;
    assign beat_fire  = blk_valid && blk_ready;
    assign final_fire = beat_fire && blk_last_pix && blk_last_block;
    assign busy       = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_acc) state_nxt = RUN;
            RUN:  if (final_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cols_q <= '0;
            rows_q <= '0;
        end else if (start_acc) begin
            cols_q <= cfg_blk_cols;
            rows_q <= cfg_blk_rows;
        end
    end

    // Write side: raster order into the bank selected by wr_ptr
    assign last_col   = {cols_q, 3'b000} - XW'(1);
    assign pix_ready  = (state == RUN) && !bank_full[wr_ptr] && (stripes_in < rows_q);
    assign wr_fire    = pix_valid && pix_ready;
    assign line_end   = (wr_col == last_col);
    assign stripe_end = wr_fire && line_end && (wr_line == 3'd7);
    assign wr_addr    = (wr_ptr ? AW'(8 * MAX_W) : '0) + AW'(wr_line) * AW'(MAX_W) + AW'(wr_col);

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            wr_ptr     <= 1'b0;
            wr_col     <= '0;
            wr_line    <= '0;
            stripes_in <= '0;
        end else if (wr_fire) begin
            if (line_end) begin
                wr_col  <= '0;
                wr_line <= wr_line + 3'd1;
                if (wr_line == 3'd7) begin
                    wr_ptr     <= ~wr_ptr;
                    stripes_in <= stripes_in + RW'(1);
                end
            end else begin
                wr_col <= wr_col + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_addr] <= pix_data;
    end

    // Fill and drain of different banks may coincide; both masks apply together
    assign bank_drain = beat_fire && out_bank_last;
    assign set_mask   = {stripe_end && wr_ptr, stripe_end && !wr_ptr};
    assign clr_mask   = {bank_drain && out_bank, bank_drain && !out_bank};

    always_ff @(posedge clk) begin
        if (rst || start_acc) bank_full <= 2'b00;
        else                  bank_full <= (bank_full | set_mask) & ~clr_mask;
    end

    // Read side: rd_ptr moves on as soon as the bank's last beat is issued;
    // the bank itself stays FULL until that beat is accepted downstream.
    assign issue          = (state == RUN) && bank_full[rd_ptr] && (!blk_valid || blk_ready);
    assign rd_blk_last    = (rd_blk == cols_q - CW'(1));
    assign rd_stripe_last = (rd_stripe == rows_q - RW'(1));
    assign blk_end        = (rd_row == 3'd7) && (rd_col == 3'd7);
    assign rd_addr        = (rd_ptr ? AW'(8 * MAX_W) : '0) + AW'(rd_row) * AW'(MAX_W) + AW'({rd_blk, rd_col});

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            rd_ptr    <= 1'b0;
            rd_blk    <= '0;
            rd_row    <= '0;
            rd_col    <= '0;
            rd_stripe <= '0;
        end else if (issue) begin
            rd_col <= rd_col + 3'd1;
            if (rd_col == 3'd7) begin
                rd_row <= rd_row + 3'd1;
                if (rd_row == 3'd7) begin
                    if (rd_blk_last) begin
                        rd_blk    <= '0;
                        rd_ptr    <= ~rd_ptr;
                        rd_stripe <= rd_stripe_last ? '0 : rd_stripe + RW'(1);
                    end else begin
                        rd_blk <= rd_blk + CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_valid      <= 1'b0;
            blk_data       <= '0;
            blk_last_pix   <= 1'b0;
            blk_last_block <= 1'b0;
            out_bank       <= 1'b0;
            out_bank_last  <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= final_fire;
            if (issue) begin
                blk_valid      <= 1'b1;
                blk_data       <= {8'h00, mem[rd_addr]};
                blk_last_pix   <= blk_end;
                blk_last_block <= rd_blk_last && rd_stripe_last;
                out_bank       <= rd_ptr;
                out_bank_last  <= blk_end && rd_blk_last;
            end else if (blk_ready) begin
                blk_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_jpeg_raster2blk.sv
// tb/tb_jpeg_raster2blk.sv - self-checking bench for jpeg_raster2blk
module tb_jpeg_raster2blk;
    logic        clk = 1'b0;
    logic        rst, start, pix_valid, blk_ready;
    logic [6:0]  cfg_blk_cols;
    logic [5:0]  cfg_blk_rows;
    logic [23:0] pix_data;
    logic        pix_ready, blk_valid, blk_last_pix, blk_last_block, busy, done;
    logic [31:0] blk_data;

    jpeg_raster2blk dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_blk_cols(cfg_blk_cols), .cfg_blk_rows(cfg_blk_rows),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_last_pix(blk_last_pix), .blk_last_block(blk_last_block),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [23:0] in_q[$];
    logic [31:0] exp_d[$], got_d[$];
    logic        exp_lp[$], exp_lb[$], got_lp[$], got_lb[$];
    logic [23:0] img[int];
    bit  in_rand, out_rand, out_hold;
    int  done_cnt, stall_changes, cyc_total, last_in_cyc, first_out_cyc, last_out_cyc;

    task automatic clear_obs();
        in_q.delete(); exp_d.delete(); exp_lp.delete(); exp_lb.delete();
        got_d.delete(); got_lp.delete(); got_lb.delete(); img.delete();
        done_cnt = 0; stall_changes = 0; first_out_cyc = -1; last_out_cyc = -1; last_in_cyc = -1;
    endtask

    // Reference: raster image, then block order derived from image coordinates
    task automatic build_frame(input int cols, input int rows, input int pat);
        int w;
        logic [23:0] v;
        w = cols * 8;
        for (int y = 0; y < rows * 8; y++)
            for (int x = 0; x < w; x++) begin
                case (pat)
                    0:       v = 24'(y * w + x);
                    1:       v = {12'(y), 12'(x)};
                    default: v = 24'($urandom);
                endcase
                img[y * w + x] = v;
                in_q.push_back(v);
            end
        for (int s = 0; s < rows; s++)
            for (int b = 0; b < cols; b++)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++) begin
                        exp_d.push_back({8'h00, img[(s * 8 + r) * w + b * 8 + c]});
                        exp_lp.push_back(r == 7 && c == 7);
                        exp_lb.push_back(s == rows - 1 && b == cols - 1);
                    end
    endtask

    task automatic do_start(input int c, input int r);
        cfg_blk_cols = 7'(c);
        cfg_blk_rows = 6'(r);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input int max_cyc, input bit stop_on_done, input int mid_start_at, output bit timed_out);
        int post;
        bit stalled;
        logic [31:0] hd;
        logic hlp, hlb;
        logic [23:0] tmp;
        post = 0; stalled = 0; hd = '0; hlp = 0; hlb = 0;
        timed_out = stop_on_done;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            pix_valid = (in_q.size() > 0) && (!in_rand || ($urandom_range(0, 2) != 0));
            pix_data  = (in_q.size() > 0) ? in_q[0] : 24'($urandom);
            blk_ready = !out_hold && (!out_rand || ($urandom_range(0, 2) != 0));
            start     = (cyc == mid_start_at);
            if (start) begin cfg_blk_cols = 7'd2; cfg_blk_rows = 6'd2; end
            @(negedge clk);
            if (pix_valid && pix_ready) begin tmp = in_q.pop_front(); last_in_cyc = cyc_total; end
            if (stalled && (!blk_valid || blk_data !== hd || blk_last_pix !== hlp || blk_last_block !== hlb))
                stall_changes++;
            if (blk_valid && first_out_cyc < 0) first_out_cyc = cyc_total;
            if (blk_valid && blk_ready) begin
                got_d.push_back(blk_data); got_lp.push_back(blk_last_pix); got_lb.push_back(blk_last_block);
                last_out_cyc = cyc_total;
            end
            stalled = blk_valid && !blk_ready;
            hd = blk_data; hlp = blk_last_pix; hlb = blk_last_block;
            if (done) done_cnt++;
            @(posedge clk); #1;
            cyc_total++;
            if (stop_on_done && done_cnt > 0) begin
                timed_out = 0;
                post++;
                if (post >= 3) break;
            end
        end
        start = 1'b0; pix_valid = 1'b0; blk_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; pix_valid = 0; blk_ready = 0; pix_data = '0;
        cfg_blk_cols = '0; cfg_blk_rows = '0; cyc_total = 0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({pix_ready, blk_valid, blk_last_pix, blk_last_block, busy, done, blk_data} !== 38'b0) begin
            errors++; $display("FAIL reset_during: outputs=%h, expected 0",
                {pix_ready, blk_valid, blk_last_pix, blk_last_block, busy, done, blk_data});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({pix_ready, blk_valid, blk_last_pix, blk_last_block, busy, done, blk_data} !== 38'b0) begin
            errors++; $display("FAIL reset_after: outputs=%h, expected 0",
                {pix_ready, blk_valid, blk_last_pix, blk_last_block, busy, done, blk_data});
        end
    endtask

    task automatic test_ramp_1x1();
        bit to;
        clear_obs(); in_rand = 0; out_rand = 0; out_hold = 0;
        build_frame(1, 1, 0);
        do_start(1, 1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ramp_busy: busy=%b, expected 1", busy); end
        run(400, 1, -1, to);
        checks++;
        if (to) begin errors++; $display("FAIL ramp_timeout: done not seen, expected done"); end
        checks++;
        if (got_d.size() != 64) begin errors++; $display("FAIL ramp_count: beats=%0d, expected 64", got_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++;
            if ({got_d[i], got_lp[i], got_lb[i]} !== {exp_d[i], exp_lp[i], exp_lb[i]}) begin
                errors++; $display("FAIL ramp_beat%0d: got %h/%b/%b, expected %h/%b/%b",
                    i, got_d[i], got_lp[i], got_lb[i], exp_d[i], exp_lp[i], exp_lb[i]);
            end
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL ramp_done: pulses=%0d, expected 1", done_cnt); end
        checks++;
        if (first_out_cyc - last_in_cyc < 1 || first_out_cyc - last_in_cyc > 3) begin
            errors++; $display("FAIL ramp_latency: %0d cycles, expected 1..3", first_out_cyc - last_in_cyc);
        end
        checks++;
        if (last_out_cyc - first_out_cyc != 63) begin
            errors++; $display("FAIL ramp_throughput: span=%0d, expected 63", last_out_cyc - first_out_cyc);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ramp_idle: busy=%b, expected 0", busy); end
    endtask

    task automatic test_two_blocks();
        bit to;
        int lb_cnt;
        clear_obs(); in_rand = 0; out_rand = 0; out_hold = 0;
        build_frame(2, 1, 1);
        do_start(2, 1);
        run(600, 1, -1, to);
        checks++;
        if (to || got_d.size() != 128) begin
            errors++; $display("FAIL twoblk_count: beats=%0d timeout=%b, expected 128 and 0", got_d.size(), to);
        end
        lb_cnt = 0;
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            if (got_lb[i]) lb_cnt++;
            checks++;
            if ({got_d[i], got_lp[i], got_lb[i]} !== {exp_d[i], exp_lp[i], exp_lb[i]}) begin
                errors++; $display("FAIL twoblk_beat%0d: got %h/%b/%b, expected %h/%b/%b",
                    i, got_d[i], got_lp[i], got_lb[i], exp_d[i], exp_lp[i], exp_lb[i]);
            end
        end
        checks++;
        if (lb_cnt != 64) begin errors++; $display("FAIL twoblk_lastblk: count=%0d, expected 64", lb_cnt); end
    endtask

    task automatic test_backpressure();
        bit to;
        clear_obs(); in_rand = 0; out_rand = 0; out_hold = 1;
        build_frame(4, 3, 2);
        do_start(4, 3);
        run(700, 0, -1, to);
        checks++;
        if (in_q.size() != 256) begin errors++; $display("FAIL bp_accepted: left=%0d, expected 256", in_q.size()); end
        checks++;
        if (pix_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: pix_ready=%b, expected 0", pix_ready); end
        checks++;
        if (got_d.size() != 0) begin errors++; $display("FAIL bp_noout: beats=%0d, expected 0", got_d.size()); end
        out_hold = 0;
        run(3000, 1, -1, to);
        checks++;
        if (to || in_q.size() != 0 || got_d.size() != exp_d.size()) begin
            errors++; $display("FAIL bp_drain: left=%0d beats=%0d timeout=%b, expected 0 %0d 0",
                in_q.size(), got_d.size(), to, exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++;
            if ({got_d[i], got_lp[i], got_lb[i]} !== {exp_d[i], exp_lp[i], exp_lb[i]}) begin
                errors++; $display("FAIL bp_beat%0d: got %h/%b/%b, expected %h/%b/%b",
                    i, got_d[i], got_lp[i], got_lb[i], exp_d[i], exp_lp[i], exp_lb[i]);
            end
        end
    endtask

    task automatic test_random_2x2();
        bit to;
        clear_obs(); in_rand = 1; out_rand = 1; out_hold = 0;
        build_frame(2, 2, 2);
        do_start(2, 2);
        run(4000, 1, -1, to);
        checks++;
        if (to || got_d.size() != 256) begin
            errors++; $display("FAIL rand_count: beats=%0d timeout=%b, expected 256 and 0", got_d.size(), to);
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++;
            if ({got_d[i], got_lp[i], got_lb[i]} !== {exp_d[i], exp_lp[i], exp_lb[i]}) begin
                errors++; $display("FAIL rand_beat%0d: got %h/%b/%b, expected %h/%b/%b",
                    i, got_d[i], got_lp[i], got_lb[i], exp_d[i], exp_lp[i], exp_lb[i]);
            end
        end
        checks++;
        if (stall_changes != 0) begin errors++; $display("FAIL rand_stall: changes=%0d, expected 0", stall_changes); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL rand_done: pulses=%0d, expected 1", done_cnt); end
        in_rand = 0; out_rand = 0;
    endtask

    task automatic test_bad_start();
        bit to;
        int bad_c[3] = '{0, 81, 1};
        int bad_r[3] = '{1, 1, 0};
        for (int k = 0; k < 3; k++) begin
            do_start(bad_c[k], bad_r[k]);
            checks++;
            if (busy !== 1'b0 || pix_ready !== 1'b0) begin
                errors++; $display("FAIL badcfg%0d: busy=%b pix_ready=%b, expected 0 0", k, busy, pix_ready);
            end
        end
        clear_obs(); out_hold = 0;
        build_frame(1, 1, 2);
        do_start(1, 1);
        run(400, 1, 10, to);
        checks++;
        if (to || got_d.size() != 64 || done_cnt != 1) begin
            errors++; $display("FAIL midstart: beats=%0d done=%0d timeout=%b, expected 64 1 0", got_d.size(), done_cnt, to);
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++;
            if ({got_d[i], got_lp[i], got_lb[i]} !== {exp_d[i], exp_lp[i], exp_lb[i]}) begin
                errors++; $display("FAIL midstart_beat%0d: got %h/%b/%b, expected %h/%b/%b",
                    i, got_d[i], got_lp[i], got_lb[i], exp_d[i], exp_lp[i], exp_lb[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit to;
        clear_obs(); out_hold = 0;
        build_frame(2, 2, 2);
        do_start(2, 2);
        run(200, 0, -1, to);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({pix_ready, blk_valid, blk_last_pix, blk_last_block, busy, done, blk_data} !== 38'b0) begin
            errors++; $display("FAIL midrst_outputs: outputs=%h, expected 0",
                {pix_ready, blk_valid, blk_last_pix, blk_last_block, busy, done, blk_data});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_obs();
        build_frame(1, 1, 0);
        do_start(1, 1);
        run(400, 1, -1, to);
        checks++;
        if (to || got_d.size() != 64 || done_cnt != 1) begin
            errors++; $display("FAIL midrst_frame: beats=%0d done=%0d timeout=%b, expected 64 1 0", got_d.size(), done_cnt, to);
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++;
            if ({got_d[i], got_lp[i], got_lb[i]} !== {exp_d[i], exp_lp[i], exp_lb[i]}) begin
                errors++; $display("FAIL midrst_beat%0d: got %h/%b/%b, expected %h/%b/%b",
                    i, got_d[i], got_lp[i], got_lb[i], exp_d[i], exp_lp[i], exp_lb[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_1x1();
        test_two_blocks();
        test_backpressure();
        test_random_2x2();
        test_bad_start();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
